// File: rtl/i2s_rx_fifo_if.sv
// Pad-side and bus-side signal bundle of the I2S receive deserialiser/FIFO.
// The design takes the slave modport; the reader/stimulus side takes master.
interface i2s_rx_fifo_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              bit_en;
  logic              din;
  logic              ws;
  logic              stereo;
  logic [1:0]        standard;
  logic [1:0]        word_size;
  logic              rd_en;
  logic              clr_ovf;
  logic [DATA_W-1:0] doutL;
  logic [DATA_W-1:0] doutR;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [LW-1:0]     level;
  logic              overflow;

  modport slave (
    input  bit_en, din, ws, stereo, standard, word_size, rd_en, clr_ovf,
    output doutL, doutR, dout_valid, full, empty, almost_full, level, overflow
  );

  modport master (
    output bit_en, din, ws, stereo, standard, word_size, rd_en, clr_ovf,
    input  doutL, doutR, dout_valid, full, empty, almost_full, level, overflow
  );
endinterface

// File: rtl/i2s_rx_fifo.sv
// I2S receive deserialiser (Philips / left-justified, stereo / mono) feeding a
// DEPTH-deep frame FIFO with registered read port, status and sticky overflow.
module i2s_rx_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic         wclk,
  input  logic         rst,
  i2s_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] LEN_16 = CW'((DATA_W < 16) ? DATA_W : 16);
  localparam logic [CW-1:0] LEN_24 = CW'((DATA_W < 24) ? DATA_W : 24);
  localparam logic [CW-1:0] LEN_32 = CW'(DATA_W);
  localparam logic [CW-1:0] MSB_POS = CW'(DATA_W - 1);
  localparam logic [PW-1:0] AF_THR  = PW'(AF_LEVEL);

  typedef enum logic [1:0] {S_IDLE, S_CAP_L, S_CAP_R, S_WAIT_L} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_ws_prev, r_ws_seen;
  logic              r_stereo, r_lj;
  logic [CW-1:0]     r_len, r_cnt, w_cnt_nxt, w_len_in, w_pos;
  logic [DATA_W-1:0] r_shift, w_shift_nxt, w_ins, w_word, r_left;
  logic              r_done, w_done_nxt, w_word_done;
  logic              w_strobe, w_start, w_lj_in, w_capturing;

  logic              r_frm_vld;
  logic [DATA_W-1:0] r_frm_l, r_frm_r;

  assign w_strobe    = bus.bit_en && r_ws_seen;
  assign w_start     = w_strobe && (bus.ws != r_ws_prev);
  assign w_lj_in     = (bus.standard == 2'b01);
  assign w_capturing = (r_state == S_CAP_L) || (r_state == S_CAP_R);
  assign w_pos       = MSB_POS - r_cnt;
  assign w_ins       = r_shift | ({{(DATA_W-1){1'b0}}, bus.din} << w_pos);

  always_comb begin
    unique case (bus.word_size)
      2'b00:   w_len_in = LEN_16;
      2'b01:   w_len_in = LEN_24;
      default: w_len_in = LEN_32;
    endcase
  end

  // NOTE: every signal gets a default before any branch, so no path leaves a
  // combinational output unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = r_done;
    w_word_done = 1'b0;
    w_word      = w_ins;
    if (w_start) begin
      // Philips: the start-strobe bit is the LSB of the word being closed.
      if (w_capturing && !r_done) begin
        w_word_done = 1'b1;
        w_word      = r_lj ? r_shift : w_ins;
      end
      unique case (r_state)
        S_IDLE:  if (!bus.ws) w_state_nxt = S_CAP_L;
        S_CAP_L: w_state_nxt = r_stereo ? S_CAP_R : S_WAIT_L;
        default: w_state_nxt = S_CAP_L;
      endcase
      w_shift_nxt = '0;
      w_cnt_nxt   = '0;
      w_done_nxt  = 1'b0;
      if (w_lj_in && (w_state_nxt == S_CAP_L || w_state_nxt == S_CAP_R)) begin
        w_shift_nxt = {bus.din, {(DATA_W-1){1'b0}}};
        w_cnt_nxt   = CW'(1);
      end
    end else if (w_strobe && w_capturing && !r_done) begin
      w_shift_nxt = w_ins;
      w_cnt_nxt   = r_cnt + CW'(1);
      if (r_cnt + CW'(1) == r_len) begin
        w_done_nxt  = 1'b1;
        w_word_done = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ws_prev <= 1'b0;
      r_ws_seen <= 1'b0;
      r_stereo  <= 1'b0;
      r_lj      <= 1'b0;
      r_len     <= LEN_16;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_left    <= '0;
      r_frm_vld <= 1'b0;
      r_frm_l   <= '0;
      r_frm_r   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_done    <= w_done_nxt;
      r_frm_vld <= 1'b0;
      if (bus.bit_en) begin
        r_ws_prev <= bus.ws;
        r_ws_seen <= 1'b1;
      end
      if (w_start) begin
        r_stereo <= bus.stereo;
        r_lj     <= w_lj_in;
        r_len    <= w_len_in;
      end
      if (w_word_done) begin
        if (r_state == S_CAP_R) begin
          r_frm_vld <= 1'b1;
          r_frm_l   <= r_left;
          r_frm_r   <= w_word;
        end else if (r_stereo) begin
          r_left <= w_word;
        end else begin
          r_frm_vld <= 1'b1;
          r_frm_l   <= w_word;
          r_frm_r   <= '0;
        end
      end
    end
  end

  logic [2*DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]       r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt, w_level_nxt;
  logic [PW-1:0]       r_level;
  logic                r_full, r_empty, r_af, r_ovf, r_dvalid;
  logic [DATA_W-1:0]   r_doutl, r_doutr;
  logic                w_push, w_pop, w_drop;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push      = r_frm_vld && (!r_full || bus.rd_en);
  assign w_drop      = r_frm_vld && !w_push;
  assign w_pop       = bus.rd_en && !r_empty;
  assign w_wptr_nxt  = r_wptr + PW'(w_push);
  assign w_rptr_nxt  = r_rptr + PW'(w_pop);
  assign w_level_nxt = w_wptr_nxt - w_rptr_nxt;

  // NOTE: the frame store has no reset; its contents are only ever read
  // behind the pointers, which are reset.
  always_ff @(posedge wclk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {r_frm_l, r_frm_r};
  end

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ovf    <= 1'b0;
      r_dvalid <= 1'b0;
      r_doutl  <= '0;
      r_doutr  <= '0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_level  <= w_level_nxt;
      r_full   <= (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]) &&
                  (w_wptr_nxt[AW] != w_rptr_nxt[AW]);
      r_empty  <= (w_wptr_nxt == w_rptr_nxt);
      r_af     <= (w_level_nxt >= AF_THR);
      r_dvalid <= w_pop;
      if (w_pop) {r_doutl, r_doutr} <= r_mem[r_rptr[AW-1:0]];
      if (w_drop)           r_ovf <= 1'b1;
      else if (bus.clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign bus.doutL       = r_doutl;
  assign bus.doutR       = r_doutr;
  assign bus.dout_valid  = r_dvalid;
  assign bus.full        = r_full;
  assign bus.empty       = r_empty;
  assign bus.almost_full = r_af;
  assign bus.level       = r_level;
  assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_i2s_rx_fifo.sv
// Scoreboard bench: an I2S bitstream is built from sample values and slot
// lengths; expected frames flow through a queue model of the FIFO.
module tb_i2s_rx_fifo;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = 6;

  logic wclk = 1'b0;
  logic rst;

  i2s_rx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  i2s_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .wclk (wclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
  } frame_t;

  int          n_checks = 0;
  int          n_errs   = 0;
  frame_t      mdl_q[$];
  frame_t      exp_q[$];
  bit          mdl_ovf = 1'b0;
  logic [31:0] last_l = '0;
  int          g_slots[$];
  logic [31:0] g_vals[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Monitor: every dout_valid pulse consumes one expected frame.
  always @(negedge wclk) begin
    frame_t f;
    if (rst === 1'b0 && bus.dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_dout_valid", 64'(bus.dout_valid), 64'd0);
      end else begin
        f = exp_q.pop_front();
        check("doutL", 64'(bus.doutL), 64'(f.l));
        check("doutR", 64'(bus.doutR), 64'(f.r));
        last_l = f.l;
      end
    end
  end

  function automatic int wlen(input logic [1:0] wsz);
    return (wsz == 2'b00) ? 16 : (wsz == 2'b01) ? 24 : 32;
  endfunction

  // Stored word: top min(slot, word length) bits of the sample, MSB-aligned.
  function automatic logic [31:0] exp_word(input logic [31:0] v, input int wl, input int slot);
    logic [63:0] w;
    logic [31:0] m;
    int          n;
    n = (slot < wl) ? slot : wl;
    w = {32'd0, v} & ((64'd1 << wl) - 64'd1);
    w = w << (32 - wl);
    m = 32'hFFFF_FFFF << (32 - n);
    return w[31:0] & m;
  endfunction

  task automatic model_push(input logic [31:0] l, input logic [31:0] r);
    frame_t f;
    f.l = l;
    f.r = r;
    if (mdl_q.size() < DEPTH) mdl_q.push_back(f);
    else mdl_ovf = 1'b1;
  endtask

  task automatic model_pop();
    if (mdl_q.size() > 0) exp_q.push_back(mdl_q.pop_front());
  endtask

  task automatic add_frame(input logic [31:0] l, input logic [31:0] r, input int sl, input int sr);
    g_vals.push_back(l);
    g_vals.push_back(r);
    g_slots.push_back(sl);
    g_slots.push_back(sr);
  endtask

  task automatic strobe(input logic w, input logic d, input bit pop_next);
    @(negedge wclk);
    bus.bit_en = 1'b1;
    bus.ws     = w;
    bus.din    = d;
    @(negedge wclk);
    bus.bit_en = 1'b0;
    bus.rd_en  = pop_next;
    @(negedge wclk);
    bus.rd_en  = 1'b0;
  endtask

  function automatic void locate(input int k, output int s, output int p);
    int  acc;
    bit  found;
    acc   = 0;
    found = 1'b0;
    s     = g_slots.size() - 1;
    p     = 0;
    for (int i = 0; i < g_slots.size(); i++) begin
      if (!found && k < acc + g_slots[i]) begin
        s     = i;
        p     = k - acc;
        found = 1'b1;
      end
      acc += g_slots[i];
    end
    if (!found) p = g_slots[s];
  endfunction

  // Plays the queued slots (L,R,L,R,...) as one bitstream after a ws=1 preamble.
  task automatic play(input bit stereo, input bit lj, input logic [1:0] wsz,
                      input bit add_model, input int pop_at, input int stop_at);
    int          wl, total, s, p, j;
    logic        w, d;
    logic [31:0] v;
    wl = wlen(wsz);
    bus.stereo    = stereo;
    bus.standard  = lj ? 2'b01 : ($urandom_range(0, 1) ? 2'b10 : 2'b00);
    bus.word_size = wsz;
    if (add_model)
      for (int f = 0; f < g_slots.size() / 2; f++)
        model_push(exp_word(g_vals[2*f], wl, g_slots[2*f]),
                   stereo ? exp_word(g_vals[2*f+1], wl, g_slots[2*f+1]) : 32'd0);
    total = 0;
    foreach (g_slots[i]) total += g_slots[i];
    for (int k = -3; k < total; k++) begin
      if (k == stop_at) break;
      j = lj ? k : k + 1;
      if (j < 0) begin
        w = 1'b1;
      end else begin
        locate(j, s, p);
        w = s[0];
      end
      if (k < 0) begin
        d = 1'($urandom_range(0, 1));
      end else begin
        locate(k, s, p);
        v = g_vals[s];
        d = (p < wl) ? 1'(v >> (wl - 1 - p)) : 1'($urandom_range(0, 1));
      end
      strobe(w, d, k == pop_at);
    end
    g_slots.delete();
    g_vals.delete();
  endtask

  task automatic pop(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge wclk);
      bus.rd_en = 1'b1;
      model_pop();
    end
    @(negedge wclk);
    bus.rd_en = 1'b0;
    repeat (2) @(negedge wclk);
  endtask

  task automatic check_status(input string tag);
    repeat (3) @(negedge wclk);
    check({tag, ".level"},       64'(bus.level),       64'(mdl_q.size()));
    check({tag, ".empty"},       64'(bus.empty),       64'(mdl_q.size() == 0));
    check({tag, ".full"},        64'(bus.full),        64'(mdl_q.size() == DEPTH));
    check({tag, ".almost_full"}, 64'(bus.almost_full), 64'(mdl_q.size() >= AF_LEVEL));
    check({tag, ".overflow"},    64'(bus.overflow),    64'(mdl_ovf));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".level"},      64'(bus.level),       64'd0);
    check({tag, ".empty"},      64'(bus.empty),       64'd1);
    check({tag, ".full"},       64'(bus.full),        64'd0);
    check({tag, ".af"},         64'(bus.almost_full), 64'd0);
    check({tag, ".overflow"},   64'(bus.overflow),    64'd0);
    check({tag, ".doutL"},      64'(bus.doutL),       64'd0);
    check({tag, ".doutR"},      64'(bus.doutR),       64'd0);
    check({tag, ".dout_valid"}, 64'(bus.dout_valid),  64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          st, lj;
    logic [1:0]  wsz;
    int          wl, nf, sl, sr;

    rst = 1'b1;
    bus.bit_en = 1'b0; bus.din = 1'b0; bus.ws = 1'b1; bus.stereo = 1'b1;
    bus.standard = 2'b00; bus.word_size = 2'b00; bus.rd_en = 1'b0; bus.clr_ovf = 1'b0;
    repeat (3) @(negedge wclk);
    check_reset("reset");
    rst = 1'b0;

    // Philips stereo 16-bit.
    add_frame(32'hA5A5, 32'h3C3C, 16, 16);
    play(1'b1, 1'b0, 2'b00, 1'b1, -100, -100);
    check_status("philips16");
    pop(1);
    check_status("philips16_popped");

    // Left-justified 24-bit words in 32-bit slots.
    add_frame(32'h123456, 32'hFEDCBA, 32, 32);
    play(1'b1, 1'b1, 2'b01, 1'b1, -100, -100);
    pop(1);

    // Mono Philips 16-bit, three frames.
    for (int i = 1; i <= 3; i++) add_frame(32'(i), 32'h5555 + 32'(i), 16, 16);
    play(1'b0, 1'b0, 2'b00, 1'b1, -100, -100);
    check_status("mono3");
    pop(3);

    // Short left channel: ws toggles after 10 bits.
    add_frame(32'hBEEF, 32'h1234, 10, 16);
    play(1'b1, 1'b0, 2'b00, 1'b1, -100, -100);
    pop(1);

    // Fill to full and beyond with no reads.
    for (int i = 0; i < 5; i++) add_frame($urandom(), $urandom(), 16, 16);
    play(1'b1, 1'b0, 2'b00, 1'b1, -100, -100);
    check_status("fill5");
    add_frame($urandom(), $urandom(), 16, 16);
    play(1'b1, 1'b0, 2'b00, 1'b1, -100, -100);
    check_status("fill6");
    for (int i = 0; i < 2; i++) add_frame($urandom(), $urandom(), 16, 16);
    play(1'b1, 1'b0, 2'b00, 1'b1, -100, -100);
    check_status("fill8");
    add_frame($urandom(), $urandom(), 16, 16);
    play(1'b1, 1'b0, 2'b00, 1'b1, -100, -100);
    check_status("fill9");
    pop(8);
    check_status("drained");
    @(negedge wclk); bus.clr_ovf = 1'b1; mdl_ovf = 1'b0;
    @(negedge wclk); bus.clr_ovf = 1'b0;
    check_status("clr_ovf");
    pop(1);
    check("empty_pop_hold", 64'(bus.doutL), 64'(last_l));

    // At full, a frame lands in the same cycle as a pop.
    for (int i = 0; i < 8; i++) add_frame($urandom(), $urandom(), 16, 16);
    play(1'b1, 1'b1, 2'b00, 1'b1, -100, -100);
    check_status("full_again");
    model_pop();
    add_frame($urandom(), $urandom(), 16, 16);
    play(1'b1, 1'b1, 2'b00, 1'b1, 31, -100);
    check_status("full_simul");
    pop(8);

    // Randomised configurations and slot lengths.
    for (int t = 0; t < 8; t++) begin
      st  = 1'($urandom_range(0, 1));
      lj  = 1'($urandom_range(0, 1));
      wsz = 2'($urandom_range(0, 3));
      wl  = wlen(wsz);
      nf  = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        sl = ($urandom_range(0, 3) == 0) ? $urandom_range(8, wl - 1) : wl + $urandom_range(0, 8);
        sr = (f == nf - 1) ? wl + $urandom_range(0, 8) :
             (($urandom_range(0, 3) == 0) ? $urandom_range(8, wl - 1) : wl + $urandom_range(0, 8));
        add_frame($urandom(), $urandom(), sl, sr);
      end
      play(st, lj, wsz, 1'b1, -100, -100);
      check_status("random");
      pop(nf);
    end

    // Reset in the middle of a right word.
    add_frame(32'hDEAD, 32'hF00D, 16, 16);
    play(1'b1, 1'b0, 2'b00, 1'b0, -100, 24);
    @(negedge wclk); rst = 1'b1;
    repeat (2) @(negedge wclk);
    check_reset("midword_reset");
    rst = 1'b0;
    add_frame(32'h0F0F, 32'h7E57, 16, 16);
    play(1'b1, 1'b0, 2'b00, 1'b1, -100, -100);
    check_status("after_reset");
    pop(1);

    repeat (5) @(negedge wclk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("model_drained", 64'(mdl_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/i2s_rx_fifo.md
# i2s_rx_fifo

Parametrised I2S receive deserialiser and frame FIFO, the successor to the fixed 8-entry receive FIFO. It samples the serial data line on a bit strobe, aligns words to the word-select line (Philips or left-justified), and assembles stereo or mono frames. Complete frames go into a DEPTH-deep FIFO with a registered read port, level/threshold status and sticky overflow detection. It sits between the I2S pad logic (bit strobe from the SCK edge detector) and the receive-side bus/DMA reader.

## Interface
- DATA_W, 32: stored sample width (16..32); samples stored MSB-aligned, unused LSBs zero
- DEPTH, 8: FIFO depth in frames, power of two, ≥2
- AF_LEVEL, DEPTH-2: almost_full asserts when level ≥ AF_LEVEL
- wclk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- bit_en  in  1  one-cycle strobe per SCK bit; din/ws sampled only when high
- din  in  1  serial data
- ws  in  1  word select (0 = left, 1 = right)
- stereo  in  1  1 = L+R frames, 0 = left-only frames
- standard  in  2  00 Philips (MSB one bit after WS edge), 01 left-justified (MSB on WS edge bit), 1x treated as 00
- word_size  in  2  00 = 16, 01 = 24, 1x = 32 bits; lengths above DATA_W truncated to DATA_W
- rd_en  in  1  pop request
- clr_ovf  in  1  clears overflow
- doutL, doutR  out  DATA_W  popped frame
- dout_valid  out  1  one-cycle pulse, doutL/doutR updated
- full, empty, almost_full  out  1  FIFO status
- level  out  $clog2(DEPTH)+1  frames stored
- overflow  out  1  sticky: frame dropped on full

## Operation
- Strobe: any wclk cycle with bit_en=1. ws_prev = ws at the previous strobe. Channel start = strobe where ws ≠ ws_prev. The first strobe after reset only loads ws_prev.
- Alignment: after reset the deserialiser stays IDLE until a channel start with ws=0. Capture therefore always begins with a left word.
- Config (stereo, standard, word_size) is latched at each channel start. Changes mid-word take effect at the next channel start.
- Left-justified: din at the channel-start strobe is the MSB. Philips: din at the channel-start strobe belongs to the previous channel (and is discarded if that word is already complete); the MSB is on the next strobe.
- Bits fill positions DATA_W-1 downward. A word completes after min(word_len, DATA_W) bits; further bits up to the next channel start are ignored. If the next channel start arrives first, the word completes there, with remaining LSBs zero.
- Deserialiser states:
  - IDLE → CAP_L on ws=0 start.
  - CAP_L → CAP_R (stereo) or WAIT_L (mono) on the next start.
  - CAP_R → CAP_L on the next start.
  - WAIT_L → CAP_L on the next start.
- Frame complete:
  - Stereo: when the right word completes.
  - Mono: when the left word completes; doutR = 0. Right-channel bits are ignored.
- Push: accepted if !full, or if full && rd_en (a simultaneous pop frees the slot). Otherwise the frame is dropped and overflow sets.
- Pop: rd_en && !empty reads the head entry; the read pointer advances. rd_en while empty is ignored, with no dout_valid and outputs held.
- Push and pop in the same cycle leave level unchanged. Pointers carry a wrap bit:
  - full = pointer indices equal and wrap bits differ.
  - empty = pointers equal.
- clr_ovf clears overflow. A drop in the same cycle wins, so overflow stays 1.

## Timing
- Reset values:
  - level = 0, empty = 1, full = 0, almost_full = 0, overflow = 0.
  - doutL = doutR = 0, dout_valid = 0.
  - Pointers 0; deserialiser IDLE, shift data 0.
  - FIFO contents need not be cleared.
- Reset mid-word discards the partial frame; the next capture needs a fresh ws=0 channel start.
- The word completes on the strobe edge T. The frame is written at edge T+1; level, empty and full reflect it after T+1.
- Read latency is 1: rd_en sampled at edge E; doutL, doutR and dout_valid are valid after E, and dout_valid falls after E+1 unless popped again.
- Back-to-back pops every cycle are supported at full throughput.
- All status outputs are registered. No combinational path from rd_en to any output.

## Test plan
- Philips, stereo, word_size=00, DATA_W=32: send L=0xA5A5 then R=0x3C3C, 16-bit slots, one pop → doutL=0xA5A50000, doutR=0x3C3C0000, dout_valid for one cycle, empty returns to 1.
- Left-justified, word_size=01: L=0x123456, R=0xFEDCBA in 32-bit slots → doutL=0x12345600, doutR=0xFEDCBA00; trailing 8 bits ignored.
- Mono, Philips, 16-bit: three frames L=0x0001, 0x0002, 0x0003 → level=3; pops return them in order with doutR=0.
- DEPTH=8, AF_LEVEL=6: push 9 stereo frames with no reads → almost_full after 6, full and level=8 after 8, overflow=1. Pops return frames 1..8 and frame 9 is lost. clr_ovf → overflow=0.
- At full, a frame completes in the same cycle as rd_en → push accepted, level stays 8, overflow stays 0.
- Short channel: ws toggles after 10 bits with word_size=00 → that word stored as its 10 bits MSB-aligned with zero LSBs.
- Reset mid-word: assert rst mid right word → all outputs at reset values. The partial frame never appears; the first frame after a new ws=0 start is stored correctly.
